// File: rtl/cache_set_assoc_if.sv
// Request/response and next-level memory bundle for one cache set.
// The cache side uses the slave modport; the requester/memory side uses master.
interface cache_set_assoc_if #(
    parameter int TAG_W      = 24,
    parameter int LINE_BYTES = 64
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = 8 * LINE_BYTES;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  req_offset;
    logic [1:0]        req_size;
    logic [63:0]       req_wdata;

    logic              resp_valid;
    logic              resp_hit;
    logic              resp_err;
    logic [63:0]       resp_rdata;

    logic              mem_req_valid;
    logic [TAG_W-1:0]  mem_req_tag;
    logic              mem_evict_dirty;
    logic [TAG_W-1:0]  mem_evict_tag;
    logic [LINE_W-1:0] mem_evict_data;
    logic              mem_fill_valid;
    logic [LINE_W-1:0] mem_fill_data;

    modport slave (
        input  req_valid, req_write, req_tag, req_offset, req_size, req_wdata,
        input  mem_fill_valid, mem_fill_data,
        output req_ready, resp_valid, resp_hit, resp_err, resp_rdata,
        output mem_req_valid, mem_req_tag, mem_evict_dirty, mem_evict_tag,
        output mem_evict_data
    );

    modport master (
        output req_valid, req_write, req_tag, req_offset, req_size, req_wdata,
        output mem_fill_valid, mem_fill_data,
        input  req_ready, resp_valid, resp_hit, resp_err, resp_rdata,
        input  mem_req_valid, mem_req_tag, mem_evict_dirty, mem_evict_tag,
        input  mem_evict_data
    );
endinterface

// File: rtl/cache_set_assoc.sv
// One N-way set: tag compare, valid/dirty, true-LRU ages, byte-granular access.
// Misses are resolved by a single fill/evict handshake, then the lookup replays.
module cache_set_assoc #(
    parameter int WAYS       = 4,
    parameter int TAG_W      = 24,
    parameter int LINE_BYTES = 64,
    parameter int DATA_W     = 64
) (
    input logic             clk,
    input logic             rst_n,
    cache_set_assoc_if.slave bus
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int AGE_W  = $clog2(WAYS);
    localparam int LINE_W = 8 * LINE_BYTES;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS, RESP} state_t;

    state_t state_q, state_d;

    logic [LINE_W-1:0] data_q [WAYS];
    logic [TAG_W-1:0]  tag_q  [WAYS];
    logic [AGE_W-1:0]  age_q  [WAYS];
    logic [AGE_W-1:0]  age_d  [WAYS];
    logic [WAYS-1:0]   valid_q, dirty_q;

    logic              r_write;
    logic [TAG_W-1:0]  r_tag;
    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [AGE_W-1:0]  victim_q, victim_d;
    logic              replay_q;

    logic              resp_hit_q, resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic [3:0]        nbytes;
    logic [OFF_W:0]    end_b;
    logic              err, hit, found;
    logic [AGE_W-1:0]  hit_way;
    logic [LINE_W-1:0] hit_line, wr_line;
    logic [DATA_W-1:0] rd_data;
    logic [OFF_W-1:0]  idx;

    logic req_ready, resp_valid, mem_req_valid;
    logic hit_go, miss_go, done_go, fill_go;

    // Bound check and tag compare on the latched request.
    always_comb begin
        nbytes  = 4'd1 << r_size;
        end_b   = {1'b0, r_off} + (OFF_W+1)'(nbytes);
        err     = end_b > (OFF_W+1)'(LINE_BYTES);
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w] && tag_q[w] == r_tag && !hit) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    assign hit_line = data_q[hit_way];

    // Byte extraction for reads and byte merge for writes; offsets wrap
    // only when err is set, in which case neither result is used.
    always_comb begin
        rd_data = '0;
        wr_line = hit_line;
        idx     = '0;
        for (int i = 0; i < 8; i++) begin
            idx = r_off + OFF_W'(i);
            if (4'(i) < nbytes) begin
                rd_data[8*i +: 8]           = hit_line[{idx, 3'b000} +: 8];
                wr_line[{idx, 3'b000} +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    // Next ages on a hit, and victim choice: lowest invalid way, else oldest.
    always_comb begin
        victim_d = '0;
        found    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            age_d[w] = age_q[w];
            if (AGE_W'(w) == hit_way)
                age_d[w] = '0;
            else if (age_q[w] < age_q[hit_way])
                age_d[w] = age_q[w] + AGE_W'(1);
            if (age_q[w] == AGE_W'(WAYS-1))
                victim_d = AGE_W'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_q[w] && !found) begin
                victim_d = AGE_W'(w);
                found    = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        hit_go        = 1'b0;
        miss_go       = 1'b0;
        done_go       = 1'b0;
        fill_go       = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (err || hit) begin
                    done_go = 1'b1;
                    hit_go  = !err;
                    state_d = RESP;
                end else begin
                    miss_go = 1'b1;
                    state_d = MISS;
                end
            end
            MISS: begin
                mem_req_valid = 1'b1;
                if (bus.mem_fill_valid) begin
                    fill_go = 1'b1;
                    state_d = LOOKUP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, victim latch and held response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write      <= 1'b0;
            r_tag        <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_wdata      <= '0;
            victim_q     <= '0;
            replay_q     <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            if (state_q == IDLE && bus.req_valid) begin
                r_write  <= bus.req_write;
                r_tag    <= bus.req_tag;
                r_off    <= bus.req_offset;
                r_size   <= bus.req_size;
                r_wdata  <= bus.req_wdata;
                replay_q <= 1'b0;
            end
            if (miss_go) begin
                victim_q <= victim_d;
                replay_q <= 1'b1;
            end
            if (done_go) begin
                resp_err_q   <= err;
                resp_hit_q   <= !err && !replay_q;
                resp_rdata_q <= (err || r_write) ? '0 : rd_data;
            end
        end
    end

    // Per-way valid, dirty, tag and LRU age state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int w = 0; w < WAYS; w++) begin
                tag_q[w] <= '0;
                age_q[w] <= AGE_W'(w);
            end
        end else begin
            if (fill_go) begin
                valid_q[victim_q] <= 1'b1;
                dirty_q[victim_q] <= 1'b0;
                tag_q[victim_q]   <= r_tag;
            end
            if (hit_go) begin
                for (int w = 0; w < WAYS; w++) age_q[w] <= age_d[w];
                if (r_write) dirty_q[hit_way] <= 1'b1;
            end
        end
    end

    // Line storage; deliberately left unreset.
    always_ff @(posedge clk) begin
        if (fill_go)
            data_q[victim_q] <= bus.mem_fill_data;
        else if (hit_go && r_write)
            data_q[hit_way] <= wr_line;
    end

    assign bus.req_ready       = req_ready;
    assign bus.resp_valid      = resp_valid;
    assign bus.resp_hit        = resp_hit_q;
    assign bus.resp_err        = resp_err_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.mem_req_valid   = mem_req_valid;
    assign bus.mem_req_tag     = r_tag;
    assign bus.mem_evict_dirty = mem_req_valid && valid_q[victim_q]
                                 && dirty_q[victim_q];
    assign bus.mem_evict_tag   = tag_q[victim_q];
    assign bus.mem_evict_data  = data_q[victim_q];
endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed bench for cache_set_assoc (4 ways, 64-byte lines).
// Fill lines carry byte k = k; expected values are worked out by hand.
module tb_cache_set_assoc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    logic [511:0] fill_line;

    cache_set_assoc_if #(.TAG_W(24), .LINE_BYTES(64)) bus ();

    cache_set_assoc #(
        .WAYS(4), .TAG_W(24), .LINE_BYTES(64), .DATA_W(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic send_req(input logic wr, input logic [23:0] tag,
                            input logic [5:0] off, input logic [1:0] sz,
                            input logic [63:0] wd);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        bus.req_write  = wr;
        bus.req_tag    = tag;
        bus.req_offset = off;
        bus.req_size   = sz;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!bus.resp_valid && cyc < 20);
        if (!bus.resp_valid) cyc = -1;
    endtask

    task automatic wait_mem(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!bus.mem_req_valid && cyc < 20);
        if (!bus.mem_req_valid) cyc = -1;
    endtask

    task automatic send_fill();
        bus.mem_fill_valid = 1'b1;
        @(posedge clk); #1;
        bus.mem_fill_valid = 1'b0;
    endtask

    task automatic miss_fill(input logic [23:0] tag);
        int c;
        send_req(1'b0, tag, 6'd0, 2'd3, 64'd0);
        wait_mem(c);
        send_fill();
        wait_resp(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.req_ready !== 1'b1)
            $display("FAIL rst_ready got %b exp 1", bus.req_ready);
        else passed++;
        total++;
        if ({bus.resp_valid, bus.resp_hit, bus.resp_err} !== 3'b000)
            $display("FAIL rst_resp got %b exp 000",
                     {bus.resp_valid, bus.resp_hit, bus.resp_err});
        else passed++;
        total++;
        if (bus.resp_rdata !== 64'd0)
            $display("FAIL rst_rdata got %h exp 0", bus.resp_rdata);
        else passed++;
        total++;
        if ({bus.mem_req_valid, bus.mem_evict_dirty} !== 2'b00)
            $display("FAIL rst_mem got %b exp 00",
                     {bus.mem_req_valid, bus.mem_evict_dirty});
        else passed++;
        total++;
        if ({bus.mem_req_tag, bus.mem_evict_tag} !== 48'd0)
            $display("FAIL rst_tags got %h exp 0",
                     {bus.mem_req_tag, bus.mem_evict_tag});
        else passed++;
    endtask

    task automatic test_miss_fill();
        int c;
        send_req(1'b0, 24'h15, 6'd0, 2'd3, 64'd0);
        wait_mem(c);
        total++;
        if (c !== 1) $display("FAIL miss_latency got %0d exp 1", c);
        else passed++;
        total++;
        if (bus.mem_req_tag !== 24'h15)
            $display("FAIL miss_tag got %h exp 15", bus.mem_req_tag);
        else passed++;
        total++;
        if (bus.mem_evict_dirty !== 1'b0)
            $display("FAIL miss_dirty got %b exp 0", bus.mem_evict_dirty);
        else passed++;
        send_fill();
        wait_resp(c);
        total++;
        if (c !== 1) $display("FAIL fill_latency got %0d exp 1", c);
        else passed++;
        total++;
        if ({bus.resp_hit, bus.resp_err} !== 2'b00)
            $display("FAIL fill_hit_err got %b exp 00",
                     {bus.resp_hit, bus.resp_err});
        else passed++;
        total++;
        if (bus.resp_rdata !== 64'h0706050403020100)
            $display("FAIL fill_rdata got %h exp 0706050403020100",
                     bus.resp_rdata);
        else passed++;
    endtask

    task automatic test_write_hit();
        int c;
        send_req(1'b1, 24'h15, 6'd8, 2'd2, 64'hDEADBEEF);
        total++;
        if (bus.req_ready !== 1'b0)
            $display("FAIL busy_t1 got %b exp 0", bus.req_ready);
        else passed++;
        wait_resp(c);
        total++;
        if (c !== 1) $display("FAIL wr_latency got %0d exp 1", c);
        else passed++;
        total++;
        if ({bus.resp_hit, bus.resp_err} !== 2'b10)
            $display("FAIL wr_hit got %b exp 10", {bus.resp_hit, bus.resp_err});
        else passed++;
        total++;
        if (bus.resp_rdata !== 64'd0)
            $display("FAIL wr_rdata got %h exp 0", bus.resp_rdata);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_hit} !== 3'b101)
            $display("FAIL t3_ready_hold got %b exp 101",
                     {bus.req_ready, bus.resp_valid, bus.resp_hit});
        else passed++;
        send_req(1'b0, 24'h15, 6'd8, 2'd3, 64'd0);
        wait_resp(c);
        total++;
        if (bus.resp_rdata !== 64'h0F0E0D0CDEADBEEF)
            $display("FAIL rd_merge got %h exp 0F0E0D0CDEADBEEF",
                     bus.resp_rdata);
        else passed++;
        send_req(1'b0, 24'h15, 6'd9, 2'd1, 64'd0);
        wait_resp(c);
        total++;
        if (bus.resp_rdata !== 64'h000000000000ADBE || bus.resp_hit !== 1'b1)
            $display("FAIL rd_half got %h/%b exp 000000000000adbe/1",
                     bus.resp_rdata, bus.resp_hit);
        else passed++;
    endtask

    task automatic test_lru_victim();
        int c;
        miss_fill(24'd1);
        miss_fill(24'd2);
        miss_fill(24'd3);
        send_req(1'b0, 24'd4, 6'd0, 2'd3, 64'd0);
        wait_mem(c);
        total++;
        if ({bus.mem_evict_dirty, bus.mem_evict_tag} !== {1'b1, 24'h15})
            $display("FAIL evict_15 got %b/%h exp 1/000015",
                     bus.mem_evict_dirty, bus.mem_evict_tag);
        else passed++;
        total++;
        if (bus.mem_evict_data[71:64] !== 8'hEF)
            $display("FAIL evict_15_byte8 got %h exp ef",
                     bus.mem_evict_data[71:64]);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({bus.mem_req_valid, bus.mem_evict_tag} !== {1'b1, 24'h15})
            $display("FAIL evict_stable got %b/%h exp 1/000015",
                     bus.mem_req_valid, bus.mem_evict_tag);
        else passed++;
        send_fill();
        wait_resp(c);
        send_req(1'b0, 24'd1, 6'd0, 2'd3, 64'd0);
        wait_resp(c);
        total++;
        if (c !== 1 || bus.resp_hit !== 1'b1)
            $display("FAIL reread_1 got %0d/%b exp 1/1", c, bus.resp_hit);
        else passed++;
        send_req(1'b0, 24'd5, 6'd0, 2'd3, 64'd0);
        wait_mem(c);
        total++;
        if ({bus.mem_evict_dirty, bus.mem_evict_tag} !== {1'b0, 24'd2})
            $display("FAIL victim_tag2 got %b/%h exp 0/000002",
                     bus.mem_evict_dirty, bus.mem_evict_tag);
        else passed++;
        send_fill();
        wait_resp(c);
    endtask

    task automatic test_dirty_evict();
        int c;
        send_req(1'b1, 24'd1, 6'd0, 2'd0, 64'hAA);
        wait_resp(c);
        total++;
        if (bus.resp_hit !== 1'b1)
            $display("FAIL wr_aa_hit got %b exp 1", bus.resp_hit);
        else passed++;
        miss_fill(24'd6);
        miss_fill(24'd7);
        miss_fill(24'd8);
        send_req(1'b0, 24'd9, 6'd0, 2'd3, 64'd0);
        wait_mem(c);
        total++;
        if ({bus.mem_evict_dirty, bus.mem_evict_tag} !== {1'b1, 24'd1})
            $display("FAIL evict_1 got %b/%h exp 1/000001",
                     bus.mem_evict_dirty, bus.mem_evict_tag);
        else passed++;
        total++;
        if (bus.mem_evict_data[15:0] !== 16'h01AA)
            $display("FAIL evict_1_data got %h exp 01aa",
                     bus.mem_evict_data[15:0]);
        else passed++;
        send_fill();
        wait_resp(c);
    endtask

    task automatic test_error();
        int c;
        send_req(1'b0, 24'd9, 6'd60, 2'd2, 64'd0);
        wait_resp(c);
        total++;
        if ({bus.resp_hit, bus.resp_err} !== 2'b10 ||
            bus.resp_rdata !== 64'h000000003F3E3D3C)
            $display("FAIL edge_rd got %b/%h exp 10/000000003f3e3d3c",
                     {bus.resp_hit, bus.resp_err}, bus.resp_rdata);
        else passed++;
        send_req(1'b0, 24'd6, 6'd62, 2'd2, 64'd0);
        wait_resp(c);
        total++;
        if (c !== 1 || bus.resp_err !== 1'b1)
            $display("FAIL err_flag got %0d/%b exp 1/1", c, bus.resp_err);
        else passed++;
        total++;
        if (bus.resp_rdata !== 64'd0 || bus.mem_req_valid !== 1'b0)
            $display("FAIL err_rdata got %h/%b exp 0/0",
                     bus.resp_rdata, bus.mem_req_valid);
        else passed++;
        send_req(1'b0, 24'd10, 6'd5, 2'd0, 64'd0);
        wait_mem(c);
        total++;
        if ({bus.mem_evict_dirty, bus.mem_evict_tag} !== {1'b0, 24'd6})
            $display("FAIL err_lru got %b/%h exp 0/000006",
                     bus.mem_evict_dirty, bus.mem_evict_tag);
        else passed++;
        send_fill();
        wait_resp(c);
        total++;
        if ({bus.resp_hit, bus.resp_err} !== 2'b00 ||
            bus.resp_rdata !== 64'h05)
            $display("FAIL after_err got %b/%h exp 00/05",
                     {bus.resp_hit, bus.resp_err}, bus.resp_rdata);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int c;
        logic seen;
        send_req(1'b0, 24'd11, 6'd0, 2'd3, 64'd0);
        wait_mem(c);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.mem_req_valid, bus.req_ready} !== 2'b01)
            $display("FAIL rst_mid got %b exp 01",
                     {bus.mem_req_valid, bus.req_ready});
        else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL rst_noresp got %b exp 0", seen);
        else passed++;
        send_req(1'b0, 24'd7, 6'd3, 2'd0, 64'd0);
        wait_mem(c);
        total++;
        if (c !== 1 || bus.mem_req_tag !== 24'd7 || bus.mem_evict_dirty !== 1'b0)
            $display("FAIL rst_remiss got %0d/%h/%b exp 1/000007/0",
                     c, bus.mem_req_tag, bus.mem_evict_dirty);
        else passed++;
        send_fill();
        wait_resp(c);
        total++;
        if (bus.resp_hit !== 1'b0 || bus.resp_rdata !== 64'h03)
            $display("FAIL rst_refill got %b/%h exp 0/03",
                     bus.resp_hit, bus.resp_rdata);
        else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 64; k++) fill_line[8*k +: 8] = 8'(k);
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_tag        = '0;
        bus.req_offset     = '0;
        bus.req_size       = '0;
        bus.req_wdata      = '0;
        bus.mem_fill_valid = 1'b0;
        bus.mem_fill_data  = fill_line;
        test_reset();
        test_miss_fill();
        test_write_hit();
        test_lru_victim();
        test_dirty_evict();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
